// File: rtl/deskew_rx_if.sv
// Signal bundle between the per-lane am_lock_rx outputs and the deskew/reorder stage,
// plus the aligned row handed on to AM removal.
interface deskew_rx_if #(
   parameter int BLOCK_W = 66,
   parameter int LANE_N  = 4
);
   // Handshake: valid_i[l] qualifies lane l's block for exactly one cycle and is always
   // accepted (no ready). valid_o is a one-cycle strobe per emitted row of LANE_N blocks.
   logic [LANE_N-1:0]         valid_i;
   logic [LANE_N-1:0]         lock_v_i;
   logic [LANE_N-1:0]         am_v_i;
   logic [LANE_N*LANE_N-1:0]  lane_i;
   logic [LANE_N*BLOCK_W-1:0] block_i;
   logic                      valid_o;
   logic                      am_v_o;
   logic [LANE_N*BLOCK_W-1:0] block_o;
   logic                      deskew_v_o;
   logic                      overflow_o;
   logic [0:0]                dbg_state_o;

   modport master (
      output valid_i, lock_v_i, am_v_i, lane_i, block_i,
      input  valid_o, am_v_o, block_o, deskew_v_o, overflow_o, dbg_state_o
   );

   modport slave (
      input  valid_i, lock_v_i, am_v_i, lane_i, block_i,
      output valid_o, am_v_o, block_o, deskew_v_o, overflow_o, dbg_state_o
   );
endinterface

// File: rtl/deskew_rx.sv
// 40GBASE-R receive deskew: per-lane block FIFOs aligned on a common alignment marker,
// then emitted one row per cycle in logical lane order.
module deskew_rx #(
   parameter int BLOCK_W = 66,
   parameter int LANE_N  = 4,
   parameter int LANE_W  = $clog2(LANE_N),
   parameter int PTR_W   = 4
) (
   input logic        clk,
   input logic        nreset,
   deskew_rx_if.slave bus
);
   localparam int DEPTH = 2 ** PTR_W;
   localparam int ENT_W = BLOCK_W + 1;
   localparam int ROW_W = LANE_N * BLOCK_W;
   localparam logic [LANE_W:0] ONE_HIT = {{LANE_W{1'b0}}, 1'b1};
   localparam logic [PTR_W:0]  PTR_ZERO = '0;

   typedef enum logic [0:0] {
      ST_WAIT    = 1'b0,
      ST_ALIGNED = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [ENT_W-1:0]   mem_q    [LANE_N][DEPTH];
   logic [PTR_W:0]     wr_ptr_q [LANE_N];
   logic [PTR_W:0]     wr_ptr_d [LANE_N];
   logic [PTR_W:0]     rd_ptr_q [LANE_N];
   logic [PTR_W:0]     rd_ptr_d [LANE_N];
   logic [LANE_W-1:0]  id_q     [LANE_N];
   logic [LANE_W-1:0]  id_d     [LANE_N];
   logic [LANE_N-1:0]  id_v_q, id_v_d;
   logic [LANE_N-1:0]  lock_q;
   logic               valid_q, valid_d;
   logic               am_q, am_d;
   logic [ROW_W-1:0]   block_q, block_d;
   logic               overflow_q, overflow_d;

   logic [LANE_N-1:0]  push, pop, empty, full, head_am, ovf, lock_fall;
   logic [BLOCK_W-1:0] head_blk [LANE_N];
   logic [LANE_N-1:0]  id_cover;
   logic               map_valid, all_nonempty, all_am, flags_eq;
   logic               emit, mismatch, flush;
   logic [LANE_W:0]    hits;
   logic [LANE_W-1:0]  idx;

   always_comb begin
      for (int l = 0; l < LANE_N; l++) begin
         push[l]     = bus.valid_i[l] & bus.lock_v_i[l];
         empty[l]    = (wr_ptr_q[l] == rd_ptr_q[l]);
         full[l]     = (wr_ptr_q[l][PTR_W] != rd_ptr_q[l][PTR_W]) &&
                       (wr_ptr_q[l][PTR_W-1:0] == rd_ptr_q[l][PTR_W-1:0]);
         head_am[l]  = mem_q[l][rd_ptr_q[l][PTR_W-1:0]][BLOCK_W];
         head_blk[l] = mem_q[l][rd_ptr_q[l][PTR_W-1:0]][BLOCK_W-1:0];
      end
   end

   // All lanes identified and every logical index 0..LANE_N-1 claimed exactly once.
   always_comb begin
      id_cover = '0;
      for (int l = 0; l < LANE_N; l++) begin
         if (id_v_q[l]) id_cover[id_q[l]] = 1'b1;
      end
      map_valid = (&id_v_q) & (&id_cover);
   end

   always_comb begin
      state_d      = state_q;
      pop          = '0;
      emit         = 1'b0;
      mismatch     = 1'b0;
      all_nonempty = ~(|empty);
      all_am       = all_nonempty & (&head_am);
      flags_eq     = (&head_am) | ~(|head_am);
      case (state_q)
         ST_WAIT: begin
            for (int l = 0; l < LANE_N; l++) begin
               pop[l] = ~empty[l] & ~head_am[l];
            end
            if (all_am) begin
               pop = '1;
               if (map_valid) begin
                  emit    = 1'b1;
                  state_d = ST_ALIGNED;
               end
            end
         end
         ST_ALIGNED: begin
            if (all_nonempty) begin
               if (flags_eq) begin
                  pop  = '1;
                  emit = 1'b1;
               end else begin
                  mismatch = 1'b1;
               end
            end
         end
         default: state_d = ST_WAIT;
      endcase
      lock_fall = lock_q & ~bus.lock_v_i;
      ovf       = push & full & ~pop;
      flush     = (|lock_fall) | (|ovf) | mismatch;
      if (flush) state_d = ST_WAIT;
   end

   always_comb begin
      id_v_d = id_v_q & ~lock_fall;
      hits   = '0;
      idx    = '0;
      for (int l = 0; l < LANE_N; l++) begin
         wr_ptr_d[l] = flush ? PTR_ZERO : wr_ptr_q[l] + {{PTR_W{1'b0}}, push[l]};
         rd_ptr_d[l] = flush ? PTR_ZERO : rd_ptr_q[l] + {{PTR_W{1'b0}}, pop[l]};
         id_d[l]     = id_q[l];
         // Zero-hot or multi-hot lane ids leave the lane unidentified.
         if (push[l] && bus.am_v_i[l]) begin
            hits = '0;
            idx  = '0;
            for (int k = 0; k < LANE_N; k++) begin
               if (bus.lane_i[l*LANE_N + k]) begin
                  hits = hits + ONE_HIT;
                  idx  = LANE_W'(k);
               end
            end
            id_d[l]   = idx;
            id_v_d[l] = (hits == ONE_HIT);
         end
      end
   end

   always_comb begin
      valid_d    = emit & ~flush;
      am_d       = valid_d & (&head_am);
      overflow_d = |ovf;
      block_d    = block_q;
      if (valid_d) begin
         for (int l = 0; l < LANE_N; l++) begin
            block_d[int'(id_q[l])*BLOCK_W +: BLOCK_W] = head_blk[l];
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= ST_WAIT;
         lock_q     <= '0;
         id_v_q     <= '0;
         valid_q    <= 1'b0;
         am_q       <= 1'b0;
         block_q    <= '0;
         overflow_q <= 1'b0;
         for (int l = 0; l < LANE_N; l++) begin
            wr_ptr_q[l] <= '0;
            rd_ptr_q[l] <= '0;
            id_q[l]     <= '0;
         end
      end else begin
         state_q    <= state_d;
         lock_q     <= bus.lock_v_i;
         id_v_q     <= id_v_d;
         valid_q    <= valid_d;
         am_q       <= am_d;
         block_q    <= block_d;
         overflow_q <= overflow_d;
         for (int l = 0; l < LANE_N; l++) begin
            wr_ptr_q[l] <= wr_ptr_d[l];
            rd_ptr_q[l] <= rd_ptr_d[l];
            id_q[l]     <= id_d[l];
         end
      end
   end

   // Storage needs no reset: pointers alone define what is valid.
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANE_N; l++) begin
         if (push[l] && !flush) begin
            mem_q[l][wr_ptr_q[l][PTR_W-1:0]] <= {bus.am_v_i[l], bus.block_i[l*BLOCK_W +: BLOCK_W]};
         end
      end
   end

   assign bus.valid_o     = valid_q;
   assign bus.am_v_o      = am_q;
   assign bus.block_o     = block_q;
   assign bus.deskew_v_o  = (state_q == ST_ALIGNED);
   assign bus.overflow_o  = overflow_q;
   assign bus.dbg_state_o = state_q;
endmodule

// File: tb/tb_deskew_rx.sv
// Directed bench for deskew_rx: lane streams with per-lane start offsets, expected rows
// computed from the logical lane index and the stream sequence number.
module tb_deskew_rx;
   localparam int BW  = 66;
   localparam int LN  = 4;
   localparam int RW  = LN * BW;
   localparam int AMP = 40;

   logic clk = 1'b0;
   logic nreset;
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int seq [LN];
   int pid [LN];
   logic [LN-1:0] corrupt;

   always #5 clk = ~clk;

   deskew_rx_if #(.BLOCK_W(BW), .LANE_N(LN)) bus ();

   deskew_rx #(.BLOCK_W(BW), .LANE_N(LN), .PTR_W(4)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   function automatic logic [BW-1:0] mk_blk(input int k, input int s, input logic am);
      logic [1:0]  sh;
      logic [31:0] tag;
      sh  = am ? 2'b10 : 2'b01;
      tag = am ? 32'hA5A5_5A5A : 32'h0000_0000;
      return {sh, tag, k[7:0], s[23:0]};
   endfunction

   function automatic logic [RW-1:0] mk_row(input int s);
      logic [RW-1:0] r;
      for (int k = 0; k < LN; k++) r[k*BW +: BW] = mk_blk(k, s, (s % AMP) == 0);
      return r;
   endfunction

   task automatic apply_reset();
      nreset       = 1'b0;
      bus.valid_i  = '0;
      bus.lock_v_i = '0;
      bus.am_v_i   = '0;
      bus.lane_i   = '0;
      bus.block_i  = '0;
      corrupt      = '0;
      for (int l = 0; l < LN; l++) seq[l] = 0;
      repeat (2) @(posedge clk);
      #1;
      nreset = 1'b1;
      cyc    = 0;
   endtask

   task automatic drive(input logic [LN-1:0] send, input logic [LN-1:0] lock);
      logic [LN-1:0] oh;
      logic am;
      for (int l = 0; l < LN; l++) begin
         oh = '0;
         oh[pid[l]] = 1'b1;
         am = ((seq[l] % AMP) == 0) && !corrupt[l];
         bus.lock_v_i[l]         = lock[l];
         bus.valid_i[l]          = send[l];
         bus.am_v_i[l]           = send[l] & am;
         bus.lane_i[l*LN +: LN]  = oh;
         bus.block_i[l*BW +: BW] = send[l] ? mk_blk(pid[l], seq[l], am) : '0;
         if (send[l]) seq[l]++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      pid = '{0, 1, 2, 3};
      apply_reset();
      total++;
      if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.valid_o); end
      total++;
      if (bus.am_v_o !== 1'b0) begin bad++; $display("FAIL rst_am got=%b exp=0", bus.am_v_o); end
      total++;
      if (bus.block_o !== '0) begin bad++; $display("FAIL rst_block got=%h exp=0", bus.block_o); end
      total++;
      if (bus.deskew_v_o !== 1'b0) begin bad++; $display("FAIL rst_deskew got=%b exp=0", bus.deskew_v_o); end
      total++;
      if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", bus.overflow_o); end
      total++;
      if (bus.dbg_state_o !== 1'b0) begin bad++; $display("FAIL rst_state got=%b exp=0", bus.dbg_state_o); end
   endtask

   task automatic test_zero_skew();
      logic e_v, e_a;
      pid = '{0, 1, 2, 3};
      apply_reset();
      for (int t = 0; t < 12; t++) begin
         drive('1, '1);
         e_v = (cyc >= 2);
         e_a = (cyc == 2);
         total++;
         if (bus.valid_o !== e_v) begin bad++; $display("FAIL t1_valid cyc=%0d got=%b exp=%b", cyc, bus.valid_o, e_v); end
         total++;
         if (bus.deskew_v_o !== e_v) begin bad++; $display("FAIL t1_deskew cyc=%0d got=%b exp=%b", cyc, bus.deskew_v_o, e_v); end
         total++;
         if (bus.am_v_o !== e_a) begin bad++; $display("FAIL t1_am cyc=%0d got=%b exp=%b", cyc, bus.am_v_o, e_a); end
         if (e_v) begin
            total++;
            if (bus.block_o !== mk_row(cyc - 2)) begin
               bad++; $display("FAIL t1_block cyc=%0d got=%h exp=%h", cyc, bus.block_o, mk_row(cyc - 2));
            end
         end
      end
   endtask

   task automatic test_reorder_skew();
      logic e_v, e_a;
      pid = '{3, 1, 0, 2};
      apply_reset();
      for (int t = 0; t < 20; t++) begin
         drive((t < 5) ? 4'b1011 : 4'b1111, '1);
         e_v = (cyc >= 7);
         e_a = (cyc == 7);
         total++;
         if (bus.valid_o !== e_v) begin bad++; $display("FAIL t2_valid cyc=%0d got=%b exp=%b", cyc, bus.valid_o, e_v); end
         total++;
         if (bus.deskew_v_o !== e_v) begin bad++; $display("FAIL t2_deskew cyc=%0d got=%b exp=%b", cyc, bus.deskew_v_o, e_v); end
         total++;
         if (bus.am_v_o !== e_a) begin bad++; $display("FAIL t2_am cyc=%0d got=%b exp=%b", cyc, bus.am_v_o, e_a); end
         total++;
         if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL t2_ovf cyc=%0d got=%b exp=0", cyc, bus.overflow_o); end
         if (e_v) begin
            total++;
            if (bus.block_o !== mk_row(cyc - 7)) begin
               bad++; $display("FAIL t2_block cyc=%0d got=%h exp=%h", cyc, bus.block_o, mk_row(cyc - 7));
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic e_v, e_a, e_o;
      logic [LN-1:0] send;
      pid = '{0, 1, 2, 3};
      apply_reset();
      for (int t = 0; t < 76; t++) begin
         if (t < 16) send = 4'b1101;
         else if (t == 30) send = 4'b0010;
         else send = 4'b1111;
         drive(send, '1);
         e_v = (cyc >= 58);
         e_a = (cyc == 58);
         e_o = (cyc == 17);
         total++;
         if (bus.overflow_o !== e_o) begin bad++; $display("FAIL t3_ovf cyc=%0d got=%b exp=%b", cyc, bus.overflow_o, e_o); end
         total++;
         if (bus.valid_o !== e_v) begin bad++; $display("FAIL t3_valid cyc=%0d got=%b exp=%b", cyc, bus.valid_o, e_v); end
         total++;
         if (bus.deskew_v_o !== e_v) begin bad++; $display("FAIL t3_deskew cyc=%0d got=%b exp=%b", cyc, bus.deskew_v_o, e_v); end
         total++;
         if (bus.am_v_o !== e_a) begin bad++; $display("FAIL t3_am cyc=%0d got=%b exp=%b", cyc, bus.am_v_o, e_a); end
         if (e_v) begin
            total++;
            if (bus.block_o !== mk_row(40 + cyc - 58)) begin
               bad++; $display("FAIL t3_block cyc=%0d got=%h exp=%h", cyc, bus.block_o, mk_row(40 + cyc - 58));
            end
         end
      end
   endtask

   task automatic test_lock_drop();
      logic e_v, e_a;
      logic [RW-1:0] e_b;
      pid = '{0, 1, 2, 3};
      apply_reset();
      for (int t = 0; t < 15; t++) begin
         if (t == 8) for (int l = 0; l < LN; l++) seq[l] = 0;
         if (t == 6) drive(4'b1101, 4'b1101);
         else drive('1, '1);
         e_v = ((cyc >= 2) && (cyc <= 6)) || (cyc >= 10);
         e_a = (cyc == 2) || (cyc == 10);
         if (cyc >= 10) e_b = mk_row(cyc - 10);
         else if (cyc <= 6) e_b = mk_row(cyc - 2);
         else e_b = mk_row(4);
         total++;
         if (bus.valid_o !== e_v) begin bad++; $display("FAIL t4_valid cyc=%0d got=%b exp=%b", cyc, bus.valid_o, e_v); end
         total++;
         if (bus.deskew_v_o !== e_v) begin bad++; $display("FAIL t4_deskew cyc=%0d got=%b exp=%b", cyc, bus.deskew_v_o, e_v); end
         total++;
         if (bus.am_v_o !== e_a) begin bad++; $display("FAIL t4_am cyc=%0d got=%b exp=%b", cyc, bus.am_v_o, e_a); end
         if (cyc >= 2) begin
            total++;
            if (bus.block_o !== e_b) begin bad++; $display("FAIL t4_block cyc=%0d got=%h exp=%h", cyc, bus.block_o, e_b); end
         end
      end
   endtask

   task automatic test_am_mismatch();
      logic e_v, e_a;
      logic [RW-1:0] e_b;
      pid = '{0, 1, 2, 3};
      apply_reset();
      for (int t = 0; t < 47; t++) begin
         corrupt = (t == 40) ? 4'b0001 : 4'b0000;
         drive('1, '1);
         e_v = (cyc >= 2) && (cyc <= 41);
         e_a = (cyc == 2);
         e_b = (cyc <= 41) ? mk_row(cyc - 2) : mk_row(39);
         total++;
         if (bus.valid_o !== e_v) begin bad++; $display("FAIL t5_valid cyc=%0d got=%b exp=%b", cyc, bus.valid_o, e_v); end
         total++;
         if (bus.deskew_v_o !== e_v) begin bad++; $display("FAIL t5_deskew cyc=%0d got=%b exp=%b", cyc, bus.deskew_v_o, e_v); end
         total++;
         if (bus.am_v_o !== e_a) begin bad++; $display("FAIL t5_am cyc=%0d got=%b exp=%b", cyc, bus.am_v_o, e_a); end
         if (cyc >= 2) begin
            total++;
            if (bus.block_o !== e_b) begin bad++; $display("FAIL t5_block cyc=%0d got=%h exp=%h", cyc, bus.block_o, e_b); end
         end
      end
   endtask

   task automatic test_dup_id();
      pid = '{1, 0, 1, 3};
      apply_reset();
      for (int t = 0; t < 50; t++) begin
         drive('1, '1);
         total++;
         if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL t6_valid cyc=%0d got=%b exp=0", cyc, bus.valid_o); end
         total++;
         if (bus.deskew_v_o !== 1'b0) begin bad++; $display("FAIL t6_deskew cyc=%0d got=%b exp=0", cyc, bus.deskew_v_o); end
      end
   endtask

   task automatic test_async_reset();
      pid = '{0, 1, 2, 3};
      apply_reset();
      repeat (5) drive('1, '1);
      total++;
      if (bus.deskew_v_o !== 1'b1) begin bad++; $display("FAIL ar_pre_deskew got=%b exp=1", bus.deskew_v_o); end
      total++;
      if (bus.block_o !== mk_row(3)) begin bad++; $display("FAIL ar_pre_block got=%h exp=%h", bus.block_o, mk_row(3)); end
      #2;
      nreset = 1'b0;
      #1;
      total++;
      if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", bus.valid_o); end
      total++;
      if (bus.deskew_v_o !== 1'b0) begin bad++; $display("FAIL ar_deskew got=%b exp=0", bus.deskew_v_o); end
      total++;
      if (bus.block_o !== '0) begin bad++; $display("FAIL ar_block got=%h exp=0", bus.block_o); end
      nreset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_zero_skew();
      test_reorder_skew();
      test_overflow();
      test_lock_drop();
      test_am_mismatch();
      test_dup_id();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
